seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Parametrised, multi-cycle restoring divider. It computes one quotient bit per clock using shift, trial-subtract and restore, behind a start/done handshake. It is the clocked, width-generic successor to the team's combinational restoring divider, and adds a busy indication and divide-by-zero handling. Intended as a shared arithmetic unit for datapaths that tolerate N+1 cycles of latency.

## Interface
- `N`, default 8: operand width in bits; legal range 2..32.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: reset, synchronous, active-high.
- `start`  input  1: request; sampled only when `busy`=0.
- `dividend`  input  N: dividend, sampled with `start`.
- `divisor`  input  N: divisor, sampled with `start`.
- `busy`  output  1: high from the cycle after accept until `done` has been issued.
- `done`  output  1: one-cycle pulse; results are valid from this cycle.
- `quotient`  output  N: registered quotient, held until the next `done`.
- `remainder`  output  N: registered remainder, held until the next `done`.
- `div_by_zero`  output  1: registered flag, qualified by `done`, held with the results.

## Operation
- FSM states: IDLE, RUN, FIN.
- **IDLE**
  - On `start`=1 with `divisor`≠0: load the working register A (2N+1 bits): upper N+1 bits = 0, lower N bits = dividend. Latch the divisor as M, zero-extended to N+1 bits. Set count = N, go to RUN.
  - On `start`=1 with `divisor`=0: set the zero flag internally and go directly to FIN.
  - `start`=0: stay in IDLE.
- **RUN**, one step per cycle:
  - Shift A left by 1.
  - Set A[2N:N] = A[2N:N] − M, computed in N+1 bits.
  - If the sign bit A[2N] = 1: restore (A[2N:N] += M) and set A[0] = 0. Otherwise set A[0] = 1.
  - Decrement count. When count reaches 1, the step is final; go to FIN.
- **FIN**, one cycle:
  - Normal result: `quotient` = A[N-1:0], `remainder` = A[2N-1:N], `div_by_zero` = 0.
  - Zero divisor: `quotient` = all ones, `remainder` = dividend, `div_by_zero` = 1.
  - `done` = 1 for this cycle only, then go to IDLE.
- `start` while `busy`=1 is ignored; inputs are not re-sampled and no queueing occurs.
- Operand inputs are only sampled in the accept cycle. Changing them during RUN has no effect.
- Arithmetic is unsigned in the default build.
- Invariant: remainder < divisor for every nonzero divisor.

## Timing
- The accept edge is cycle 0. `busy`=1 during cycles 1..N+1. The N RUN steps occupy edges 1..N. `done`=1 in cycle N+1. `busy`=0 in cycle N+2, and a new `start` can be accepted at that edge.
  - Throughput: one operation per N+2 cycles.
- Zero divisor: `done` in cycle 1, with `busy`=1 during cycle 1 only.
- The `done` output is registered; there is no combinational path from inputs to outputs.
- Reset (effective at a clock edge, in any state including mid-RUN):
  - FSM returns to IDLE and the in-flight operation is discarded.
  - `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0; A, M and count = 0.
  - A `start` in the same cycle as `rst` is ignored.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- **Defined:** operands and results are two's complement.
  - At accept, the magnitudes of dividend and divisor are loaded, and the quotient sign (XOR of the operand signs) and the dividend sign are latched.
  - The unsigned core is unchanged.
  - In FIN, the quotient is negated if the quotient sign is set, and the remainder is negated if the dividend sign is set. Division truncates toward zero and the remainder takes the dividend's sign.
  - The most-negative ÷ −1 case yields quotient = 2^(N−1) (wrapped) and remainder 0; no flag is raised.
  - Zero divisor behaves as in the unsigned build.
  - Latency is identical to the unsigned build.
- **Undefined:** unsigned only. No sign logic is synthesised.

## Test plan
- N=8, dividend=100, divisor=7, `start` pulse → `done` exactly in cycle 9, quotient=14, remainder=2, `div_by_zero`=0, `busy` high during cycles 1–9.
- N=8: 255÷1 → quotient=255, remainder=0. 5÷9 → quotient=0, remainder=5. 200÷200 → quotient=1, remainder=0.
- N=8, divisor=0, dividend=0x5A → `done` in cycle 1, quotient=0xFF, remainder=0x5A, `div_by_zero`=1.
- Second `start` with new operands in cycle 4 of a 100÷7 run → ignored; result still 14 r 2; the next operation is accepted at cycle 10.
- `rst` asserted in cycle 5 of a run → all outputs 0 the next cycle, no `done` pulse. A fresh 63÷8 afterwards → quotient=7, remainder=7.
- `DIV_SIGNED_EN` defined, N=8:
  - −7÷2 → quotient=0xFD (−3), remainder=0xFF (−1).
  - 7÷−2 → quotient=0xFD, remainder=0x01.
  - −128÷−1 → quotient=0x80, remainder=0x00.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/done handshake and operand/result bundle for seq_restoring_divider
interface seq_restoring_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional two's-complement operands when DIV_SIGNED_EN is defined.
module seq_restoring_divider #(
  parameter int N = 8
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [2*N:0]  a_q;
  logic [N:0]    m_q;
  logic [CW-1:0] count_q;

  logic [2*N:0]  a_shift;
  logic [N:0]    trial;
  logic [2*N:0]  a_next;
  logic [N-1:0]  dd_mag;
  logic [N-1:0]  dv_mag;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;
`endif

  // One restoring step: shift, trial-subtract, keep the difference only if it did not go negative.
  always_comb begin
    a_shift = {a_q[2*N-1:0], 1'b0};
    trial   = a_shift[2*N:N] - m_q;
    a_next  = a_shift;
    if (trial[N]) begin
      a_next[0] = 1'b0;
    end else begin
      a_next[2*N:N] = trial;
      a_next[0]     = 1'b1;
    end
  end

`ifdef DIV_SIGNED_EN
  always_comb begin
    dd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    dv_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
    q_fin  = q_neg ? -a_next[N-1:0]   : a_next[N-1:0];
    r_fin  = r_neg ? -a_next[2*N-1:N] : a_next[2*N-1:N];
  end
`else
  always_comb begin
    dd_mag = bus.dividend;
    dv_mag = bus.divisor;
    q_fin  = a_next[N-1:0];
    r_fin  = a_next[2*N-1:N];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      a_q             <= '0;
      m_q             <= '0;
      count_q         <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.divisor == '0) begin
              // Zero divisor skips RUN; results are posted directly so done lands in cycle 1.
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= FIN;
            end else begin
              a_q     <= {{(N+1){1'b0}}, dd_mag};
              m_q     <= {1'b0, dv_mag};
              count_q <= CW'(N);
`ifdef DIV_SIGNED_EN
              q_neg   <= bus.dividend[N-1] ^ bus.divisor[N-1];
              r_neg   <= bus.dividend[N-1];
`endif
              state   <= RUN;
            end
          end
        end
        RUN: begin
          a_q     <= a_next;
          count_q <= count_q - 1'b1;
          if (count_q == CW'(1)) begin
            bus.quotient    <= q_fin;
            bus.remainder   <= r_fin;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            state           <= FIN;
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  seq_restoring_divider_if #(.N(N)) bus ();

  seq_restoring_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is accepted at the following posedge (cycle 0).
  task automatic run_vec(input vec_t v);
    int           done_cyc = 0;
    logic         busy_ok  = 1'b1;
    logic [N-1:0] q = '0;
    logic [N-1:0] r = '0;
    logic         z = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = v.dd;
    bus.divisor  = v.dv;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.dividend = 8'hA5;
        bus.divisor  = 8'h03;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        done_cyc = k;
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        break;
      end
    end
    chk($sformatf("done_cycle %0h/%0h", v.dd, v.dv), done_cyc, v.lat);
    chk($sformatf("busy_span %0h/%0h", v.dd, v.dv), busy_ok, 1);
    chk($sformatf("quotient %0h/%0h", v.dd, v.dv), q, v.q);
    chk($sformatf("remainder %0h/%0h", v.dd, v.dv), r, v.r);
    chk($sformatf("div_by_zero %0h/%0h", v.dd, v.dv), z, v.z);
    @(negedge clk);
    chk($sformatf("idle_after %0h/%0h", v.dd, v.dv), {bus.busy, bus.done}, 2'b00);
    chk($sformatf("held_quotient %0h/%0h", v.dd, v.dv), bus.quotient, v.q);
  endtask

  initial begin
    int d1 = 0, d2 = 0;
    logic [N-1:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
    logic busy10 = 1'b1;
    logic saw_done = 1'b0;

    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9});
    vecs.push_back('{8'h5A,  8'd0,   8'hFF,  8'h5A,  1'b1, 1});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 9});
    vecs.push_back('{8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 9});
    vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 9});
    vecs.push_back('{8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0, 9});
    vecs.push_back('{8'd63,  8'd8,   8'd7,   8'd7,   1'b0, 9});
`else
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9});
    vecs.push_back('{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 9});
    vecs.push_back('{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 9});
`endif

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, '0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start during busy is ignored; the held request is taken once busy drops.
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 4) begin
        bus.start = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor = 8'd3;
      end
      if (k == 10) busy10 = bus.busy;
      if (k == 11) bus.start = 1'b0;
      if (bus.done && d1 == 0) begin
        d1 = k; q1 = bus.quotient; r1 = bus.remainder;
      end else if (bus.done) begin
        d2 = k; q2 = bus.quotient; r2 = bus.remainder;
      end
    end
    chk("ignored_start_done1", d1, 9);
    chk("ignored_start_result1", {q1, r1}, {8'd14, 8'd2});
    chk("ignored_start_busy_c10", busy10, 0);
    chk("ignored_start_done2", d2, 19);
    chk("ignored_start_result2", {q2, r2}, {8'd16, 8'd2});

    // Reset mid-run, with a start presented in the same cycle as rst.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 8'd63;
    bus.divisor = 8'd8;
    @(negedge clk);
    chk("midrun_reset_outputs", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, '0);
    rst = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("no_activity_after_reset", saw_done, 0);
    run_vec('{8'd63, 8'd8, 8'd7, 8'd7, 1'b0, 9});

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule
